// File: rtl/multicycle_control_pkg.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control_pkg
// Purpose  : Shared definitions for the multicycle controller: the FSM state
//            enumeration, opcode/funct constants, control-field encodings and
//            the instruction-class record produced by op_decode.
// Revision : 1.0 - initial release
// ============================================================================
package multicycle_control_pkg;

  // Controller states (state_o exposes this encoding for debug).
  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADR  = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_RTEX    = 4'd7,
    S_RTWB    = 4'd8,
    S_BRANCH  = 4'd9,
    S_ORIEX   = 4'd10,
    S_ORIWB   = 4'd11,
    S_JUMP    = 4'd12,
    S_ILLEGAL = 4'd13
  } state_t;

  // Opcode field values.
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BLTZ  = 6'b000001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_JRS   = 6'b010010;
  localparam logic [5:0] OP_BALN  = 6'b011011;

  // Funct field values.
  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_JMSUB = 6'b100010;
  localparam logic [5:0] FN_OR    = 6'b100101;

  // ALU operation class.
  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;
  localparam logic [1:0] ALUOP_JUMP   = 2'b11;

  // PC source mux.
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Immediate extender mode.
  localparam logic [1:0] EXT_SIGN  = 2'b00;
  localparam logic [1:0] EXT_ZERO  = 2'b01;
  localparam logic [1:0] EXT_SHAMT = 2'b10;

  // ALU B-operand mux.
  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_BROFF = 2'b11;

  // Instruction-class one-hots. An opcode with no bit set is illegal.
  typedef struct packed {
    logic rtype;
    logic lw;
    logic sw;
    logic branch;
    logic ori;
    logic jump;
    logic baln;   // jump variant that also links (writes a register)
    logic sll;    // R-type shift, uses the shamt extender path
  } op_class_t;

endpackage : multicycle_control_pkg
`default_nettype wire

// File: rtl/multicycle_control_op_decode.sv
`default_nettype none
// ============================================================================
// Module   : op_decode
// Purpose  : Combinational opcode/funct classifier for the multicycle
//            controller.
// Ports    : in   [5:0] - opcode field
//            fun  [5:0] - funct field
//            cls        - instruction-class one-hots (all zero = illegal)
// Revision : 1.0 - initial release
// ============================================================================
module op_decode
  import multicycle_control_pkg::*;
(
  input  logic [5:0] in,
  input  logic [5:0] fun,
  output op_class_t  cls
);

  always_comb begin
    cls = '0;
    case (in)
      OP_RTYPE: begin
        cls.rtype = 1'b1;
        cls.sll   = (fun == FN_SLL);
      end
      OP_LW:            cls.lw     = 1'b1;
      OP_SW:            cls.sw     = 1'b1;
      OP_BEQ, OP_BLTZ:  cls.branch = 1'b1;
      OP_ORI:           cls.ori    = 1'b1;
      OP_JRS:           cls.jump   = 1'b1;
      OP_BALN: begin
        cls.jump = 1'b1;
        cls.baln = 1'b1;
      end
      default:          cls = '0;
    endcase
  end

endmodule : op_decode
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control
// Purpose  : Moore control unit for a multicycle processor datapath with a
//            configurable memory wait (each access lasts MEM_WAIT+1 cycles).
// Params   : MEM_WAIT - extra wait cycles per memory access (0..15)
//            CNT_W    - wait-counter width, 2**CNT_W must exceed MEM_WAIT
// Ports    : clk, reset (async, active-high)
//            in/fun        - opcode / funct fields of the instruction register
//            pcwrite, pcwritecond, iord, irwrite, memread, memwrite,
//            memtoreg, regdest, regwrite, alusrca - 1-bit controls
//            alusrcb, aluop, pcsource, ext - 2-bit controls
//            fout    - function code to ALU control
//            illegal - one-cycle pulse on an unsupported opcode
//            state_o - current state (debug)
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int MEM_WAIT = 0,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] in,
  input  logic [5:0] fun,
  output logic       pcwrite,
  output logic       pcwritecond,
  output logic       iord,
  output logic       irwrite,
  output logic       memread,
  output logic       memwrite,
  output logic       memtoreg,
  output logic       regdest,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] pcsource,
  output logic [1:0] ext,
  output logic [5:0] fout,
  output logic       illegal,
  output logic [3:0] state_o
);

  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_WAIT);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             wait_done;
  op_class_t        cls;

  op_decode u_op_decode (
    .in  (in),
    .fun (fun),
    .cls (cls)
  );

  assign wait_done = (cnt == WAIT_LAST);
  assign state_o   = state;

  // State register and wait counter. The counter saturates at MEM_WAIT and
  // is cleared on every transition into a memory-access state (FETCH, MEMRD,
  // MEMWR); the later clear assignments override the saturating increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      if (!wait_done) cnt <= cnt + 1'b1;
      case (state)
        S_IDLE: begin
          state <= S_FETCH;
          cnt   <= '0;
        end
        S_FETCH: begin
          if (wait_done) state <= S_DECODE;
        end
        S_DECODE: begin
          if (cls.lw || cls.sw)  state <= S_MEMADR;
          else if (cls.rtype)    state <= S_RTEX;
          else if (cls.branch)   state <= S_BRANCH;
          else if (cls.ori)      state <= S_ORIEX;
          else if (cls.jump)     state <= S_JUMP;
          else                   state <= S_ILLEGAL;
        end
        S_MEMADR: begin
          state <= cls.lw ? S_MEMRD : S_MEMWR;
          cnt   <= '0;
        end
        S_MEMRD: begin
          if (wait_done) state <= S_MEMWB;
        end
        S_MEMWR: begin
          if (wait_done) begin
            state <= S_FETCH;
            cnt   <= '0;
          end
        end
        S_RTEX:  state <= S_RTWB;
        S_ORIEX: state <= S_ORIWB;
        S_MEMWB, S_RTWB, S_BRANCH, S_ORIWB, S_JUMP, S_ILLEGAL: begin
          state <= S_FETCH;
          cnt   <= '0;
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Output decode from the registered state. Because state clears
  // asynchronously, every output drops to zero the moment reset asserts.
  // fout tracks fun live so ALU control sees the current funct field.
  always_comb begin
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    iord        = 1'b0;
    irwrite     = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    memtoreg    = 1'b0;
    regdest     = 1'b0;
    regwrite    = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = SRCB_REG;
    aluop       = ALUOP_ADD;
    pcsource    = PCSRC_ALU;
    ext         = EXT_SIGN;
    fout        = fun;
    illegal     = 1'b0;
    case (state)
      S_IDLE: fout = '0;
      S_FETCH: begin
        memread = 1'b1;
        alusrcb = SRCB_FOUR;
        // Latch IR and advance PC only once the memory data is valid.
        irwrite = wait_done;
        pcwrite = wait_done;
      end
      S_DECODE: alusrcb = SRCB_BROFF;
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
      end
      S_MEMRD: begin
        memread = 1'b1;
        iord    = 1'b1;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      S_MEMWR: begin
        memwrite = 1'b1;
        iord     = 1'b1;
      end
      S_RTEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
        if (cls.sll) begin
          alusrcb = SRCB_IMM;
          ext     = EXT_SHAMT;
        end
      end
      S_RTWB: begin
        regdest  = 1'b1;
        regwrite = 1'b1;
      end
      S_BRANCH: begin
        alusrca     = 1'b1;
        aluop       = ALUOP_BRANCH;
        pcwritecond = 1'b1;
        pcsource    = PCSRC_BRANCH;
      end
      S_ORIEX: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        ext     = EXT_ZERO;
        aluop   = ALUOP_FUNCT;
        fout    = FN_OR;
      end
      S_ORIWB: regwrite = 1'b1;
      S_JUMP: begin
        aluop    = ALUOP_JUMP;
        pcwrite  = 1'b1;
        pcsource = PCSRC_JUMP;
        regwrite = cls.baln;
      end
      S_ILLEGAL: illegal = 1'b1;
      default: fout = '0;
    endcase
  end

endmodule : multicycle_control
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_control
// Purpose  : Self-checking bench for multicycle_control. Three instances with
//            MEM_WAIT = 0, 2, 3 share clock, reset and instruction inputs; a
//            per-instruction reference model builds the expected per-cycle
//            output vectors, which are compared against the selected DUT.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;
  import multicycle_control_pkg::*;

  typedef struct packed {
    logic [3:0] st;
    logic       pcwrite, pcwritecond, iord, irwrite, memread, memwrite;
    logic       memtoreg, regdest, regwrite, alusrca;
    logic [1:0] alusrcb, aluop, pcsource, ext;
    logic [5:0] fout;
    logic       illegal;
  } vec_t;

  logic       clk;
  logic       reset;
  logic [5:0] instr_op;
  logic [5:0] fun;
  wire  [28:0] obs [3];

  int errors = 0;
  int checks = 0;

  vec_t       eq  [$];
  logic [5:0] opq [$];
  logic [5:0] fnq [$];

  function automatic int wait_of(input int idx);
    return (idx == 0) ? 0 : ((idx == 1) ? 2 : 3);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic       pcwrite, pcwritecond, iord, irwrite, memread, memwrite;
    logic       memtoreg, regdest, regwrite, alusrca, illegal;
    logic [1:0] alusrcb, aluop, pcsource, ext;
    logic [5:0] fout;
    logic [3:0] state_o;
    multicycle_control #(
      .MEM_WAIT ((g == 0) ? 0 : ((g == 1) ? 2 : 3)),
      .CNT_W    (4)
    ) dut (
      .clk (clk), .reset (reset), .in (instr_op), .fun (fun),
      .pcwrite (pcwrite), .pcwritecond (pcwritecond), .iord (iord),
      .irwrite (irwrite), .memread (memread), .memwrite (memwrite),
      .memtoreg (memtoreg), .regdest (regdest), .regwrite (regwrite),
      .alusrca (alusrca), .alusrcb (alusrcb), .aluop (aluop),
      .pcsource (pcsource), .ext (ext), .fout (fout),
      .illegal (illegal), .state_o (state_o)
    );
    assign obs[g] = {state_o, pcwrite, pcwritecond, iord, irwrite, memread,
                     memwrite, memtoreg, regdest, regwrite, alusrca, alusrcb,
                     aluop, pcsource, ext, fout, illegal};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- model
  function automatic vec_t blank(input state_t s, input logic [5:0] fn);
    vec_t v;
    v      = '0;
    v.st   = s;
    v.fout = fn;
    return v;
  endfunction

  task automatic push(input vec_t v, input logic [5:0] op, input logic [5:0] fn);
    eq.push_back(v);
    opq.push_back(op);
    fnq.push_back(fn);
  endtask

  function automatic vec_t fetch_cycle(input logic [5:0] fn, input bit last);
    vec_t v;
    v         = blank(S_FETCH, fn);
    v.memread = 1'b1;
    v.alusrcb = 2'b01;
    v.irwrite = last;
    v.pcwrite = last;
    return v;
  endfunction

  task automatic begin_prog(input logic [5:0] op, input logic [5:0] fn);
    eq.delete(); opq.delete(); fnq.delete();
    push(blank(S_IDLE, 6'd0), op, fn);
  endtask

  task automatic end_prog(input logic [5:0] op, input logic [5:0] fn, input int w);
    push(fetch_cycle(fn, w == 0), op, fn);
  endtask

  // Appends every cycle of one instruction, fetch through write-back.
  task automatic add_instr(input logic [5:0] op, input logic [5:0] fn, input int w);
    vec_t v;
    for (int k = 0; k <= w; k++) push(fetch_cycle(fn, k == w), op, fn);
    v = blank(S_DECODE, fn); v.alusrcb = 2'b11; push(v, op, fn);
    case (op)
      6'b100011, 6'b101011: begin
        v = blank(S_MEMADR, fn); v.alusrca = 1'b1; v.alusrcb = 2'b10;
        push(v, op, fn);
        if (op == 6'b100011) begin
          for (int k = 0; k <= w; k++) begin
            v = blank(S_MEMRD, fn); v.memread = 1'b1; v.iord = 1'b1;
            push(v, op, fn);
          end
          v = blank(S_MEMWB, fn); v.regwrite = 1'b1; v.memtoreg = 1'b1;
          push(v, op, fn);
        end else begin
          for (int k = 0; k <= w; k++) begin
            v = blank(S_MEMWR, fn); v.memwrite = 1'b1; v.iord = 1'b1;
            push(v, op, fn);
          end
        end
      end
      6'b000000: begin
        v = blank(S_RTEX, fn); v.alusrca = 1'b1; v.aluop = 2'b10;
        if (fn == 6'b000000) begin v.alusrcb = 2'b10; v.ext = 2'b10; end
        push(v, op, fn);
        v = blank(S_RTWB, fn); v.regdest = 1'b1; v.regwrite = 1'b1;
        push(v, op, fn);
      end
      6'b000100, 6'b000001: begin
        v = blank(S_BRANCH, fn); v.alusrca = 1'b1; v.aluop = 2'b01;
        v.pcwritecond = 1'b1; v.pcsource = 2'b01;
        push(v, op, fn);
      end
      6'b001101: begin
        v = blank(S_ORIEX, 6'b100101); v.alusrca = 1'b1; v.alusrcb = 2'b10;
        v.ext = 2'b01; v.aluop = 2'b10;
        push(v, op, fn);
        v = blank(S_ORIWB, fn); v.regwrite = 1'b1; push(v, op, fn);
      end
      6'b010010, 6'b011011: begin
        v = blank(S_JUMP, fn); v.aluop = 2'b11; v.pcwrite = 1'b1;
        v.pcsource = 2'b10; v.regwrite = (op == 6'b011011);
        push(v, op, fn);
      end
      default: begin
        v = blank(S_ILLEGAL, fn); v.illegal = 1'b1; push(v, op, fn);
      end
    endcase
  endtask

  // --------------------------------------------------------------- driving
  // Leaves the bench just after reset release, mid-cycle, DUTs in IDLE.
  task automatic apply_reset();
    @(posedge clk); #3;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
  endtask

  // Walks the expectation queue one cycle per entry (first entry is the
  // current IDLE cycle), driving in/fun and comparing at posedge+2.
  task automatic check_prog(input int idx, input string name, input int limit);
    int n;
    n = (limit < 0 || limit > eq.size()) ? eq.size() : limit;
    for (int k = 0; k < n; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      instr_op = opq[k];
      fun      = fnq[k];
      #1;
      checks++;
      if (obs[idx] !== eq[k]) begin
        errors++;
        $display("FAIL %s dut%0d cycle %0d: got %h expected %h",
                 name, idx, k, obs[idx], eq[k]);
      end
    end
  endtask

  task automatic run_one(input int idx, input string name,
                         input logic [5:0] op, input logic [5:0] fn);
    apply_reset();
    begin_prog(op, fn);
    add_instr(op, fn, wait_of(idx));
    end_prog(op, fn, wait_of(idx));
    check_prog(idx, name, -1);
  endtask

  function automatic logic [5:0] rand_op();
    logic [5:0] legal [8];
    int r;
    legal = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
              6'b000001, 6'b001101, 6'b010010, 6'b011011};
    r = int'($urandom_range(0, 9));
    if (r < 8) return legal[r];
    if (r == 8) return 6'b111111;
    return 6'($urandom());
  endfunction

  function automatic logic [5:0] rand_fn();
    int r;
    r = int'($urandom_range(0, 2));
    if (r == 0) return 6'b000000;
    if (r == 1) return 6'b100010;
    return 6'($urandom());
  endfunction

  // ----------------------------------------------------------------- tests
  task automatic test_reset();
    reset    = 1'b1;
    instr_op = 6'b100011;
    fun      = 6'b101010;
    repeat (2) @(posedge clk);
    #2;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs[i] !== 29'(blank(S_IDLE, 6'd0))) begin
        errors++;
        $display("FAIL reset_state dut%0d: got %h expected %h",
                 i, obs[i], blank(S_IDLE, 6'd0));
      end
    end
    #1 reset = 1'b0;
  endtask

  task automatic test_lw();
    run_one(0, "lw_w0", 6'b100011, 6'b010101);
    run_one(2, "lw_w3", 6'b100011, 6'b000011);
  endtask

  task automatic test_sw_wait();
    run_one(1, "sw_w2", 6'b101011, 6'b110000);
    run_one(0, "sw_w0", 6'b101011, 6'b000001);
  endtask

  task automatic test_ori();
    run_one(0, "ori_w0", 6'b001101, 6'b000111);
    run_one(1, "ori_w2", 6'b001101, 6'b111000);
  endtask

  task automatic test_rtype();
    run_one(0, "sll", 6'b000000, 6'b000000);
    run_one(0, "jmsub", 6'b000000, 6'b100010);
    run_one(2, "rtype_w3", 6'b000000, 6'b100000);
  endtask

  task automatic test_branch_jump();
    run_one(0, "beq", 6'b000100, 6'b001001);
    run_one(1, "bltz", 6'b000001, 6'b000000);
    run_one(0, "jrs", 6'b010010, 6'b011110);
    run_one(1, "baln", 6'b011011, 6'b100010);
  endtask

  task automatic test_illegal();
    run_one(0, "illegal_ff", 6'b111111, 6'b000000);
    run_one(2, "illegal_ff_w3", 6'b111111, 6'b100101);
    run_one(1, "illegal_3f_near", 6'b100100, 6'b000010);
  endtask

  task automatic test_reset_mid_access();
    apply_reset();
    begin_prog(6'b100011, 6'b001100);
    add_instr(6'b100011, 6'b001100, 3);
    // IDLE + 4 FETCH + DECODE + MEMADR + 2 of the 4 MEMRD cycles.
    check_prog(2, "lw_pre_reset", 9);
    #1 reset = 1'b1;
    #1;
    checks++;
    if (obs[2] !== 29'(blank(S_IDLE, 6'd0))) begin
      errors++;
      $display("FAIL reset_async dut2: got %h expected %h",
               obs[2], blank(S_IDLE, 6'd0));
    end
    @(posedge clk); #1;
    checks++;
    if (obs[2] !== 29'(blank(S_IDLE, 6'd0))) begin
      errors++;
      $display("FAIL reset_hold dut2: got %h expected %h",
               obs[2], blank(S_IDLE, 6'd0));
    end
    #2 reset = 1'b0;
    begin_prog(6'b100011, 6'b001100);
    add_instr(6'b100011, 6'b001100, 3);
    end_prog(6'b100011, 6'b001100, 3);
    check_prog(2, "lw_after_reset", -1);
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops [6];
    logic [5:0] fns [6];
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 6; j++) begin
        ops[j] = rand_op();
        fns[j] = rand_fn();
      end
      apply_reset();
      begin_prog(ops[0], fns[0]);
      for (int j = 0; j < 6; j++) add_instr(ops[j], fns[j], wait_of(i));
      end_prog(ops[5], fns[5], wait_of(i));
      check_prog(i, "back_to_back", -1);
    end
  endtask

  initial begin
    reset    = 1'b1;
    instr_op = '0;
    fun      = '0;
    test_reset();
    test_lw();
    test_sw_wait();
    test_ori();
    test_rtype();
    test_branch_jump();
    test_illegal();
    test_reset_mid_access();
    for (int r = 0; r < 4; r++) test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_multicycle_control
`default_nettype wire
